// File: rtl/pad_bank_pkg.sv
// Shared constants for the pad bank controller.
// Register word addresses and register-port address width.
package pad_bank_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] REG_DIR     = 3'd0;
    localparam logic [ADDR_W-1:0] REG_OUT     = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IN      = 3'd2;
    localparam logic [ADDR_W-1:0] REG_IRQ_EN  = 3'd3;
    localparam logic [ADDR_W-1:0] REG_RISE_EN = 3'd4;
    localparam logic [ADDR_W-1:0] REG_FALL_EN = 3'd5;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 3'd6;
    localparam logic [ADDR_W-1:0] REG_OUT_TGL = 3'd7;

endpackage

// File: rtl/pad_in_filter.sv
// Single-pin input path: two-flop synchroniser, stability filter
// and rise/fall detection aligned with the filtered-value update.
module pad_in_filter #(
    parameter int   FILTER_CYCLES = 1,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILTER_CYCLES) + 1;

    logic          sync1;
    logic          sync2;
    logic          filt_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Any bounce back to the filtered level restarts the count.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        if (sync2 != filt) begin
            if (cnt == CW'(FILTER_CYCLES - 1))
                filt_next = sync2;
            else
                cnt_next = cnt + 1'b1;
        end
    end

    assign rise = filt_next & ~filt;
    assign fall = ~filt_next & filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
            filt  <= IDLE_LEVEL;
            cnt   <= '0;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
            filt  <= filt_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/pad_bank_ctrl.sv
// Register-programmable bank of bidirectional pads with filtered
// inputs, edge capture and a masked level interrupt.
import pad_bank_pkg::*;

module pad_bank_ctrl #(
    parameter int   N             = 8,
    parameter int   FILTER_CYCLES = 1,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic              soc_clk,
    input  logic              soc_aresetn,
    input  logic              reg_req,
    input  logic              reg_we,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [N-1:0]      reg_wdata,
    output logic [N-1:0]      reg_rdata,
    output logic              reg_ack,
    input  logic [N-1:0]      pad_i,
    output logic [N-1:0]      pad_o,
    output logic [N-1:0]      pad_t,
    output logic              irq
);

    logic [N-1:0] dir;
    logic [N-1:0] out;
    logic [N-1:0] irq_en;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] status;
    logic [N-1:0] status_clr;
    logic [N-1:0] status_set;
    logic [N-1:0] filt;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] rd_val;
    logic         wr;
    logic         rd;

    for (genvar i = 0; i < N; i++) begin : g_pin
        pad_in_filter #(
            .FILTER_CYCLES(FILTER_CYCLES),
            .IDLE_LEVEL   (IDLE_LEVEL)
        ) u_filt (
            .clk  (soc_clk),
            .rst_n(soc_aresetn),
            .pad  (pad_i[i]),
            .filt (filt[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign wr = reg_req & reg_we;
    assign rd = reg_req & ~reg_we;

    assign pad_t = dir;
    assign pad_o = out;

    // A fresh event outranks a same-cycle clear.
    assign status_clr = (wr && reg_addr == REG_STATUS) ? reg_wdata : '0;
    assign status_set = (rise & rise_en) | (fall & fall_en);

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            REG_DIR:     rd_val = dir;
            REG_OUT:     rd_val = out;
            REG_IN:      rd_val = filt;
            REG_IRQ_EN:  rd_val = irq_en;
            REG_RISE_EN: rd_val = rise_en;
            REG_FALL_EN: rd_val = fall_en;
            REG_STATUS:  rd_val = status;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge soc_clk or negedge soc_aresetn) begin
        if (!soc_aresetn) begin
            dir       <= '1;
            out       <= '0;
            irq_en    <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            status    <= '0;
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr) begin
                case (reg_addr)
                    REG_DIR:     dir     <= reg_wdata;
                    REG_OUT:     out     <= reg_wdata;
                    REG_IRQ_EN:  irq_en  <= reg_wdata;
                    REG_RISE_EN: rise_en <= reg_wdata;
                    REG_FALL_EN: fall_en <= reg_wdata;
                    REG_OUT_TGL: out     <= out ^ reg_wdata;
                    default:     ;
                endcase
            end
            status    <= (status & ~status_clr) | status_set;
            reg_ack   <= reg_req;
            reg_rdata <= rd ? rd_val : '0;
            irq       <= |(status & irq_en);
        end
    end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Scoreboard bench: accesses push expected responses, a negedge
// monitor pops them on reg_ack and checks data and latency.
module tb_pad_bank_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         reg_req;
    logic         reg_we;
    logic [2:0]   reg_addr;
    logic [N-1:0] reg_wdata;
    logic [N-1:0] reg_rdata;
    logic         reg_ack;
    logic [N-1:0] pad_i;
    logic [N-1:0] pad_o;
    logic [N-1:0] pad_t;
    logic         irq;

    typedef struct {
        bit           rd;
        logic [N-1:0] data;
        int           cyc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    pad_bank_ctrl #(
        .N(N),
        .FILTER_CYCLES(4),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .soc_clk    (clk),
        .soc_aresetn(rst_n),
        .reg_req    (reg_req),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .pad_i      (pad_i),
        .pad_o      (pad_o),
        .pad_t      (pad_t),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding access,
    // exactly one cycle after it was issued.
    always @(negedge clk) begin
        if (reg_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack: got ack expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_lat"}, cyc, e.cyc + 1);
                if (e.rd)
                    chk(e.name, reg_rdata, e.data);
                else
                    chk({e.name, "_rdata0"}, reg_rdata, '0);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc - 1) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack expected ack", e.name);
        end
    end

    task automatic acc(input string name, input bit we,
                       input logic [2:0] a, input logic [N-1:0] d,
                       input logic [N-1:0] exp);
        exp_t e;
        e.rd   = !we;
        e.data = exp;
        e.cyc  = cyc;
        e.name = name;
        exp_q.push_back(e);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = a;
        reg_wdata = d;
        @(posedge clk);
        #1;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input string name, input logic [2:0] a,
                      input logic [N-1:0] exp);
        acc(name, 1'b0, a, '0, exp);
    endtask

    task automatic wr(input string name, input logic [2:0] a,
                      input logic [N-1:0] d);
        acc(name, 1'b1, a, d, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        pad_i     = '0;
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_pad_t", pad_t, 8'hFF);
        chk("rst_pad_o", pad_o, 8'h00);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ack", reg_ack, 1'b0);
        rd("rst_dir", 3'd0, 8'hFF);
        rd("rst_out", 3'd1, 8'h00);
        rd("rst_status", 3'd6, 8'h00);
        rd("rst_in", 3'd2, 8'h00);

        wr("w_dir", 3'd0, 8'h0F);
        chk("pad_t_dir", pad_t, 8'h0F);
        wr("w_out", 3'd1, 8'hA5);
        chk("pad_o_out", pad_o, 8'hA5);
        wr("w_tgl", 3'd7, 8'h03);
        chk("pad_o_tgl", pad_o, 8'hA6);
        rd("r_out_tgl", 3'd1, 8'hA6);
        rd("r_tgl_zero", 3'd7, 8'h00);

        // 3-cycle pulse: filtered input never moves
        for (int t = 0; t < 12; t++) begin
            pad_i[2] = (t < 3);
            rd("in_short", 3'd2, 8'h00);
        end
        idle(4);

        // 6-cycle pulse: IN[2] set 5 edges after first sample
        for (int t = 0; t < 12; t++) begin
            pad_i[2] = (t < 6);
            rd("in_long", 3'd2, (t >= 6) ? 8'h04 : 8'h00);
        end
        idle(4);
        rd("in_long_fall", 3'd2, 8'h00);

        wr("w_rise_en", 3'd4, 8'h04);
        wr("w_irq_en", 3'd3, 8'h04);
        pad_i[2] = 1'b1;
        idle(6);
        chk("irq_lag", irq, 1'b0);
        idle(1);
        chk("irq_set", irq, 1'b1);
        rd("status_rise", 3'd6, 8'h04);
        wr("w1c_status", 3'd6, 8'h04);
        chk("irq_hold", irq, 1'b1);
        idle(1);
        chk("irq_drop", irq, 1'b0);
        rd("status_clr", 3'd6, 8'h00);

        wr("w_fall_en", 3'd5, 8'h01);
        pad_i[0] = 1'b1;
        idle(10);
        rd("status_no_rise0", 3'd6, 8'h00);
        pad_i[0] = 1'b0;
        idle(5);
        wr("w1c_race", 3'd6, 8'h01);
        rd("status_set_wins", 3'd6, 8'h01);
        chk("irq_masked", irq, 1'b0);

        wr("w_irq_en0", 3'd3, 8'h01);
        wr("w_dir0", 3'd0, 8'h00);
        chk("pad_t_drive", pad_t, 8'h00);
        chk("irq_pre_rst", irq, 1'b1);
        rd("burst_rd", 3'd1, 8'hA6);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_pad_t", pad_t, 8'hFF);
        chk("async_irq", irq, 1'b0);
        chk("async_ack", reg_ack, 1'b0);
        idle(2);
        #3;
        rst_n = 1'b1;
        idle(1);
        rd("post_dir", 3'd0, 8'hFF);
        rd("post_out", 3'd1, 8'h00);
        rd("post_status", 3'd6, 8'h00);
        rd("post_irq_en", 3'd3, 8'h00);
        idle(3);
        chk("q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
